seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller for the `clk_sys` domain. It latches a wide hex word from the PS2 receive path on `rd_vld` and time-multiplexes it across `DIGITS` common-anode digits. The word may be wider than the display; a window selects which nibbles are shown, either statically or by auto-scrolling. Options are leading-zero blanking, per-digit decimal points and a blank mode. It drives the board anode and segment pins directly.

---
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode seven-segment controller.
// A wide hex word is latched on rd_vld and scanned across DIGITS digits.
// A nibble window is selected statically (low/high) or by circular auto-scroll.
// Leading-zero blanking, per-digit decimal points and a blank mode are supported.
// Anode and segment outputs are registered and active-low.
module seg7_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int BUF_NIBBLES = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 50000000
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     rd_vld,
    input  logic [4*BUF_NIBBLES-1:0] rd_data,
    input  logic [1:0]               mode,
    input  logic                     lz_blank,
    input  logic [DIGITS-1:0]        dp_mask,
    output logic [DIGITS-1:0]        SEG_SELECT_OUT,
    output logic [7:0]               HEX_OUT
);

    localparam int D_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OFF_W = (BUF_NIBBLES > 1) ? $clog2(BUF_NIBBLES) : 1;
    localparam int RC_W  = $clog2(REFRESH_DIV);
    localparam int SC_W  = $clog2(SCROLL_DIV);

    localparam logic [1:0] MODE_LOW    = 2'b00;
    localparam logic [1:0] MODE_HIGH   = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;

    localparam logic [OFF_W-1:0] OFF_HIGH = OFF_W'(BUF_NIBBLES - DIGITS);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BUF_NIBBLES - 1);
    localparam logic [D_W-1:0]   DIG_LAST = D_W'(DIGITS - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_DIV - 1);

    logic [4*BUF_NIBBLES-1:0] data_q;
    logic [RC_W-1:0]          ref_cnt;
    logic [D_W-1:0]           dig_idx;
    logic [SC_W-1:0]          scr_cnt;
    logic [OFF_W-1:0]         off_q;
    logic [1:0]               prev_mode;

    logic [OFF_W-1:0]  off_eff;
    logic [3:0]        show_nib;
    logic              nz_above;
    logic              blank_dig;
    int                pos;
    logic [DIGITS-1:0] seg_nxt;
    logic [7:0]        hex_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Data latch: capture the hex word whenever a read strobe arrives, in any mode.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (rd_vld) begin
            data_q <= rd_data;
        end
    end

    // Refresh scan: each digit slot lasts REFRESH_DIV cycles, digits cycle 0..DIGITS-1.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            dig_idx <= '0;
        end else if (ref_cnt == RC_LAST) begin
            ref_cnt <= '0;
            dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Window offset and scroll timer; entering scroll mode restarts from offset 0.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            off_q     <= '0;
            scr_cnt   <= '0;
            prev_mode <= MODE_BLANK;
        end else begin
            prev_mode <= mode;
            case (mode)
                MODE_LOW:  off_q <= '0;
                MODE_HIGH: off_q <= OFF_HIGH;
                MODE_SCROLL: begin
                    if (prev_mode != MODE_SCROLL) begin
                        off_q   <= '0;
                        scr_cnt <= '0;
                    end else if (scr_cnt == SC_LAST) begin
                        scr_cnt <= '0;
                        off_q   <= (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
                    end else begin
                        scr_cnt <= scr_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Offset seen by the output stage this cycle, so a mode change shows on the next edge.
    always_comb begin
        case (mode)
            MODE_LOW:    off_eff = '0;
            MODE_HIGH:   off_eff = OFF_HIGH;
            MODE_SCROLL: off_eff = (prev_mode != MODE_SCROLL) ? '0 : off_q;
            default:     off_eff = off_q;
        endcase
    end

    // Select the current digit's nibble and detect all-zero nibbles from here upward.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        show_nib = '0;
        nz_above = 1'b0;
        pos      = 0;
        for (int j = 0; j < DIGITS; j++) begin
            pos = int'(off_eff) + j;
            if (pos >= BUF_NIBBLES) pos = pos - BUF_NIBBLES;
            if (j >= int'(dig_idx) && data_q[4*pos +: 4] != 4'h0) nz_above = 1'b1;
            if (j == int'(dig_idx)) show_nib = data_q[4*pos +: 4];
        end
        blank_dig = (mode == MODE_LOW || mode == MODE_HIGH) && lz_blank &&
                    (dig_idx != '0) && !nz_above;
    end

    // Next anode/segment values for the digit currently being scanned.
    always_comb begin
        if (mode == MODE_BLANK || blank_dig) begin
            seg_nxt = '1;
            hex_nxt = 8'hFF;
        end else begin
            seg_nxt = ~(DIGITS'(1) << dig_idx);
            hex_nxt = {~dp_mask[dig_idx], hex7(show_nib)};
        end
    end

    // Registered board outputs; dark while in reset.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            SEG_SELECT_OUT <= '1;
            HEX_OUT        <= 8'hFF;
        end else begin
            SEG_SELECT_OUT <= seg_nxt;
            HEX_OUT        <= hex_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: table-driven scans plus hand-written corner sequences.
module tb_seg7_scan_ctrl;

    localparam int DIGITS      = 4;
    localparam int BUF_NIBBLES = 6;
    localparam int REFRESH_DIV = 4;
    localparam int SCROLL_DIV  = 64;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        rd_vld;
    logic [23:0] rd_data;
    logic [1:0]  mode;
    logic        lz_blank;
    logic [3:0]  dp_mask;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;

    seg7_scan_ctrl #(
        .DIGITS(DIGITS), .BUF_NIBBLES(BUF_NIBBLES),
        .REFRESH_DIV(REFRESH_DIV), .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .rd_vld(rd_vld), .rd_data(rd_data),
        .mode(mode), .lz_blank(lz_blank), .dp_mask(dp_mask),
        .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string           nm;
        logic [1:0]      mode;
        logic            lz;
        logic [3:0]      dp;
        logic            ld;
        logic [23:0]     data;
        logic [3:0][7:0] hex;
        logic [3:0][3:0] seg;
    } vec_t;

    typedef struct {
        string      nm;
        logic [3:0] seg;
        logic [7:0] hex;
    } exp_t;

    logic [7:0] dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input string nm, input logic [1:0] m, input logic lz,
                                input logic [3:0] dp, input logic ld, input logic [23:0] data,
                                input logic [3:0][7:0] hex, input logic [3:0][3:0] seg);
        vec_t v;
        v.nm = nm; v.mode = m; v.lz = lz; v.dp = dp; v.ld = ld; v.data = data;
        v.hex = hex; v.seg = seg;
        return v;
    endfunction

    function automatic logic [3:0] seg_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic check(input string nm, input logic [3:0] as, input logic [7:0] ah,
                         input logic [3:0] es, input logic [7:0] eh);
        n_vec++;
        if (as !== es || ah !== eh) begin
            n_err++;
            $display("FAIL %s (cyc %0d): got seg=%h hex=%h, expected seg=%h hex=%h",
                     nm, cyc, as, ah, es, eh);
        end
    endtask

    // One clock edge; when chk is set the expectation goes through the scoreboard.
    task automatic step(input bit chk, input string nm, input logic [3:0] es,
                        input logic [7:0] eh);
        exp_t e;
        if (chk) begin
            e.nm = nm; e.seg = es; e.hex = eh;
            sb.push_back(e);
        end
        @(posedge clk_sys);
        cyc++;
        #1;
        if (chk) begin
            e = sb.pop_front();
            check(e.nm, SEG_SELECT_OUT, HEX_OUT, e.seg, e.hex);
        end
    endtask

    initial begin
        int          d;
        int          off;
        int          p;
        logic [23:0] sdata;

        vecs.push_back(mk("low",    2'b00, 1'b0, 4'b0000, 1'b1, 24'h123456,
                          {8'hB0, 8'h99, 8'h92, 8'h82}, {4'h7, 4'hB, 4'hD, 4'hE}));
        vecs.push_back(mk("high",   2'b01, 1'b0, 4'b0010, 1'b0, 24'h000000,
                          {8'hF9, 8'hA4, 8'h30, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE}));
        vecs.push_back(mk("lz5",    2'b00, 1'b1, 4'b0000, 1'b1, 24'h000005,
                          {8'hFF, 8'hFF, 8'hFF, 8'h92}, {4'hF, 4'hF, 4'hF, 4'hE}));
        vecs.push_back(mk("lz105",  2'b00, 1'b1, 4'b0000, 1'b1, 24'h000105,
                          {8'hFF, 8'hF9, 8'hC0, 8'h92}, {4'hF, 4'hB, 4'hD, 4'hE}));
        vecs.push_back(mk("lz0",    2'b00, 1'b1, 4'b0000, 1'b1, 24'h000000,
                          {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'hE}));
        vecs.push_back(mk("lz0dp",  2'b00, 1'b1, 4'b1111, 1'b0, 24'h000000,
                          {8'hFF, 8'hFF, 8'hFF, 8'h40}, {4'hF, 4'hF, 4'hF, 4'hE}));
        vecs.push_back(mk("blank",  2'b11, 1'b0, 4'b0000, 1'b1, 24'h000009,
                          {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {4'hF, 4'hF, 4'hF, 4'hF}));
        vecs.push_back(mk("unblank", 2'b00, 1'b0, 4'b0000, 1'b0, 24'h000000,
                          {8'hC0, 8'hC0, 8'hC0, 8'h90}, {4'h7, 4'hB, 4'hD, 4'hE}));

        rst = 1'b1; rd_vld = 1'b0; rd_data = '0; mode = 2'b00; lz_blank = 1'b0; dp_mask = '0;
        #12;
        check("por", SEG_SELECT_OUT, HEX_OUT, 4'hF, 8'hFF);
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        cyc = 0;
        step(1'b1, "por_rel", 4'hE, 8'hC0);

        // Table: configure, let one edge absorb the load, then check a full scan.
        foreach (vecs[i]) begin
            mode = vecs[i].mode; lz_blank = vecs[i].lz; dp_mask = vecs[i].dp;
            if (vecs[i].ld) begin
                rd_vld = 1'b1; rd_data = vecs[i].data;
            end
            step(1'b0, "", '0, '0);
            rd_vld = 1'b0;
            for (int k = 0; k < DIGITS * REFRESH_DIV; k++) begin
                d = (cyc / REFRESH_DIV) % DIGITS;
                step(1'b1, vecs[i].nm, vecs[i].seg[d], vecs[i].hex[d]);
            end
        end

        // rd_vld on the edge where the digit advances: old data now, new data next edge.
        while (cyc % REFRESH_DIV != REFRESH_DIV - 1) step(1'b0, "", '0, '0);
        rd_vld = 1'b1; rd_data = 24'h777777;
        d = (cyc / REFRESH_DIV) % DIGITS;
        step(1'b1, "sim_old", seg_of(d), (d == 0) ? 8'h90 : 8'hC0);
        rd_vld = 1'b0;
        d = (cyc / REFRESH_DIV) % DIGITS;
        step(1'b1, "sim_new", seg_of(d), 8'hF8);

        // Auto-scroll through more than one full wrap of the window.
        sdata = 24'hABCDEF;
        mode = 2'b00; lz_blank = 1'b0; dp_mask = '0;
        rd_vld = 1'b1; rd_data = sdata;
        step(1'b0, "", '0, '0);
        rd_vld = 1'b0;
        mode = 2'b10;
        for (int k = 0; k < (BUF_NIBBLES + 1) * SCROLL_DIV; k++) begin
            off = (k == 0) ? 0 : ((k - 1) / SCROLL_DIV) % BUF_NIBBLES;
            d = (cyc / REFRESH_DIV) % DIGITS;
            p = (off + d) % BUF_NIBBLES;
            step(1'b1, "scroll", seg_of(d), dec[sdata[4*p +: 4]]);
        end

        // Reset mid-scan clears outputs immediately and the latch with them.
        mode = 2'b00;
        step(1'b0, "", '0, '0);
        step(1'b0, "", '0, '0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", SEG_SELECT_OUT, HEX_OUT, 4'hF, 8'hFF);
        @(posedge clk_sys);
        #1;
        check("rst_hold", SEG_SELECT_OUT, HEX_OUT, 4'hF, 8'hFF);
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 2 * REFRESH_DIV; k++) begin
            d = (cyc / REFRESH_DIV) % DIGITS;
            step(1'b1, "rst_rel", seg_of(d), 8'hC0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
